cxscreen_scan: RTL
==================

// Module: cxscreen_scan
// PURPOSE
//   Scan controller for the 7-pin charlieplexed LED screen (42 LEDs). Owns a
//   double-buffered 7x7 pixel map, time-multiplexes one anode row at a time,
//   and drives the per-pin tristate pair cxscreen_oe/cxscreen_o that feeds the
//   board-level SB_IO cells. Sits between the bus-side register logic in top
//   and the I/O pads.
// PARAMETERS
//   ROW_BITS    10  drive phase per row lasts 2**ROW_BITS clocks (min 4)
//   DEAD_TICKS  16  all-pins-tristate blanking clocks before each row (>=1)
// PORTS
//   clock         in   1  system clock
//   reset_n       in   1  asynchronous, active-low reset
//   wr_en         in   1  write one pixel into the back buffer this cycle
//   wr_row        in   3  anode pin index 0..6
//   wr_col        in   3  cathode pin index 0..6
//   wr_data       in   1  pixel value (1 = lit)
//   swap          in   1  1-cycle request: copy back buffer to front at next frame start
//   swap_pending  out  1  swap requested, not yet applied
//   frame_start   out  1  1-cycle pulse when row 0 blanking begins
//   cxscreen_oe   out  7  per-pin output enable (0 = high-Z)
//   cxscreen_o    out  7  per-pin output level
// BEHAVIOUR
// - One clock, reset is asynchronous and active-low; no other clock domains.
// - Reset: state DEAD, row=0, counter=0, front/back buffers all 0,
//   cxscreen_oe=0, cxscreen_o=0, swap_pending=0, frame_start=0.
// - FSM, two states:
//   - DEAD: lasts DEAD_TICKS clocks with all oe=0, o=0, then DRIVE.
//   - DRIVE: lasts 2**ROW_BITS clocks, then row advances (6 wraps to 0) and
//     the FSM returns to DEAD.
// - DRIVE outputs for row r:
//   - anode pin: oe[r]=1, o[r]=1.
//   - every c!=r: oe[c]=front[r][c], o[c]=0.
// - All outputs are registered and take their new value on the same edge
//   that enters the state. No cycle ever has two pins driven high.
// - Frame period = 7*(DEAD_TICKS + 2**ROW_BITS) clocks.
// - Writes:
//   - wr_en with row!=col and both <=6 sets back[row][col] <= wr_data.
//   - row==col or any index 7: write is ignored.
//   - Writes never touch the front buffer.
// - Swap:
//   - swap sets swap_pending. At the row 6 -> row 0 transition with
//     swap_pending=1: front <= back, swap_pending <= 0.
//   - A swap arriving on that same boundary cycle is applied at that boundary.
//   - A write on the boundary cycle goes to back only; the copy uses back
//     before that write.
//   - A repeat swap while pending has no extra effect.
// - frame_start pulses for 1 clock on entry to DEAD of row 0, including the
//   first DEAD after reset.
// - Reset asserted mid-frame: immediate return to reset values, pins high-Z.
// CONFIGURATION
//   CXSCREEN_BRIGHTNESS_EN defined:
//   - adds input brightness[3:0], sampled on entry to DRIVE.
//   - During DRIVE, cathode oe[c] is gated by
//     (counter >> (ROW_BITS-4)) < brightness.
//   - 0 = dark; 15 = lit for 15/16 of the drive phase.
//   - Anode pin timing is unchanged.
//   Not defined: no brightness port; cathodes are enabled for the full drive
//   phase.
// TESTING
//   1 reset -> oe=0, o=0, swap_pending=0; frame_start pulse on cycle 1 after
//     release; DEAD 16 clks then row 0 DRIVE 1024 clks.
//   2 write (r=2,c=5,1), swap -> swap_pending=1 until frame boundary; during
//     row 2: oe=7'b0100100, o=7'b0000100; other rows: only anode oe bit set.
//   3 write (r=3,c=3,1) and (r=7,c=0,1), swap -> front unchanged, no pin is
//     ever driven low.
//   4 swap and write(0,1,1) on the boundary cycle -> swap applied; pixel
//     (0,1) not visible until the next swap.
//   5 reset_n low during row 4 DRIVE -> same-edge oe=0; after release,
//     restart at row 0 with cleared buffers.
//   6 CXSCREEN_BRIGHTNESS_EN, brightness=4, ROW_BITS=10 -> cathode oe high
//     for the first 256 of 1024 drive clocks; brightness=0 -> cathodes
//     never enabled.

Source files
------------

// File: rtl/cxscreen_scan_if.sv
// cxscreen_scan_if
//   Bus-side connection between the register logic in top and the
//   charlieplex scan controller.
//   Signals:
//     wr_en        write one pixel into the back buffer this cycle
//     wr_row       anode pin index of the pixel (0..6)
//     wr_col       cathode pin index of the pixel (0..6)
//     wr_data      pixel value, 1 = lit
//     swap         1-cycle request to copy back -> front at the next frame start
//     swap_pending swap requested but not yet applied
//     frame_start  1-cycle pulse when row 0 blanking begins
//   Modports: master = register logic, slave = scan controller.
interface cxscreen_scan_if;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic       wr_data;
  logic       swap;
  logic       swap_pending;
  logic       frame_start;

  modport master (
    output wr_en, wr_row, wr_col, wr_data, swap,
    input  swap_pending, frame_start
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_data, swap,
    output swap_pending, frame_start
  );
endinterface

// File: rtl/cxscreen_scan.sv
// cxscreen_scan
//   Scan controller for the 7-pin charlieplexed LED screen (42 LEDs).
//   Holds a double-buffered 7x7 pixel map and drives one anode row at a
//   time: each row gets DEAD_TICKS clocks of all-pins-tristate blanking
//   followed by 2**ROW_BITS clocks of drive. During drive the anode pin is
//   driven high and every lit cathode of that row is driven low; unlit pins
//   stay high-Z. All pin outputs are registered.
//   Ports:
//     clock, reset_n  system clock, asynchronous active-low reset
//     bus             cxscreen_scan_if.slave (pixel writes, swap, status)
//     brightness      [3:0] drive duty in 1/16 steps (optional, see below)
//     cxscreen_oe     [6:0] per-pin output enable (0 = high-Z)
//     cxscreen_o      [6:0] per-pin output level
//   Optional feature macro: CXSCREEN_BRIGHTNESS_EN
//     When defined, adds the brightness input. It is sampled on entry to a
//     row's drive phase, and cathodes are only enabled while the top four
//     bits of the drive counter are below it. The anode is unaffected.
module cxscreen_scan #(
  parameter int ROW_BITS   = 10,
  parameter int DEAD_TICKS = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  cxscreen_scan_if.slave bus,
`ifdef CXSCREEN_BRIGHTNESS_EN
  input  logic [3:0]     brightness,
`endif
  output logic [6:0]     cxscreen_oe,
  output logic [6:0]     cxscreen_o
);

  // One counter serves both phases, so it must hold the longer of the two.
  localparam int DEAD_W = $clog2(DEAD_TICKS + 1);
  localparam int CW     = (ROW_BITS > DEAD_W) ? ROW_BITS : DEAD_W;

  localparam logic [0:0]    ST_DEAD    = 1'b0;
  localparam logic [0:0]    ST_DRIVE   = 1'b1;
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_TICKS - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'((64'd1 << ROW_BITS) - 64'd1);
  localparam logic [2:0]    LAST_ROW   = 3'd6;

  logic [0:0]       state;
  logic [2:0]       row;
  logic [CW-1:0]    counter;
  // Set by reset so that the first edge after release emits frame_start
  // and opens the row 0 blanking window.
  logic             boot;
  logic [6:0][6:0]  front;
  logic [6:0][6:0]  back;
  logic             swap_pending;
  logic             frame_start;

  logic [0:0]       state_nx;
  logic [2:0]       row_nx;
  logic [CW-1:0]    counter_nx;
  logic [6:0]       oe_nx;
  logic [6:0]       o_nx;
  logic             frame_start_nx;
  logic             boundary;
  logic             enter_drive;

  logic [6:0]       anode;
  logic [6:0]       cathodes;
  logic [6:0]       entry_cath;
  logic [6:0]       hold_cath;
  logic             wr_ok;

  assign anode    = 7'b000_0001 << row;
  assign cathodes = front[row] & ~anode;
  assign wr_ok    = bus.wr_en && (bus.wr_row != bus.wr_col) &&
                    (bus.wr_row <= 3'd6) && (bus.wr_col <= 3'd6);

  assign bus.swap_pending = swap_pending;
  assign bus.frame_start  = frame_start;

`ifdef CXSCREEN_BRIGHTNESS_EN
  logic [3:0] bright_level;

  // Cathodes are enabled while the drive phase is in its first
  // 'level' sixteenths; the top four counter bits give the sixteenth.
  function automatic logic [6:0] dim_cathodes(input logic [6:0]    cath,
                                              input logic [CW-1:0] cnt,
                                              input logic [3:0]    level);
    logic [3:0] slice;
    slice = 4'(cnt >> (ROW_BITS - 4));
    return (slice < level) ? cath : 7'b000_0000;
  endfunction

  // Entry uses the live input because that is the sampling edge.
  assign entry_cath = dim_cathodes(cathodes, CNT_ZERO, brightness);
  assign hold_cath  = dim_cathodes(cathodes, counter + CNT_ONE, bright_level);

  // Brightness level latched on entry to each drive phase.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bright_level <= 4'd0;
    end else if (enter_drive) begin
      bright_level <= brightness;
    end
  end
`else
  assign entry_cath = cathodes;
  assign hold_cath  = cathodes;
`endif

  // Next-state, next-output and frame-boundary decode.
  always_comb begin
    state_nx       = state;
    row_nx         = row;
    counter_nx     = counter + CNT_ONE;
    oe_nx          = 7'b000_0000;
    o_nx           = 7'b000_0000;
    frame_start_nx = 1'b0;
    boundary       = 1'b0;
    enter_drive    = 1'b0;
    if (boot) begin
      counter_nx     = CNT_ZERO;
      frame_start_nx = 1'b1;
    end else begin
      case (state)
        ST_DEAD: begin
          if (counter == DEAD_LAST) begin
            state_nx    = ST_DRIVE;
            counter_nx  = CNT_ZERO;
            enter_drive = 1'b1;
            oe_nx       = anode | entry_cath;
            o_nx        = anode;
          end else begin
            oe_nx = 7'b000_0000;
            o_nx  = 7'b000_0000;
          end
        end
        ST_DRIVE: begin
          if (counter == DRIVE_LAST) begin
            state_nx       = ST_DEAD;
            counter_nx     = CNT_ZERO;
            row_nx         = (row >= LAST_ROW) ? 3'd0 : row + 3'd1;
            frame_start_nx = (row >= LAST_ROW);
            boundary       = (row >= LAST_ROW);
          end else begin
            oe_nx = anode | hold_cath;
            o_nx  = anode;
          end
        end
        default: begin
          state_nx   = ST_DEAD;
          row_nx     = 3'd0;
          counter_nx = CNT_ZERO;
        end
      endcase
    end
  end

  // Scan state and registered pin outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_DEAD;
      row         <= 3'd0;
      counter     <= CNT_ZERO;
      boot        <= 1'b1;
      cxscreen_oe <= 7'b000_0000;
      cxscreen_o  <= 7'b000_0000;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      row         <= row_nx;
      counter     <= counter_nx;
      boot        <= 1'b0;
      cxscreen_oe <= oe_nx;
      cxscreen_o  <= o_nx;
      frame_start <= frame_start_nx;
    end
  end

  // Pixel buffers and swap handshake. The copy reads back before any
  // same-cycle write lands, and a swap on the boundary cycle counts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      front        <= '0;
      back         <= '0;
      swap_pending <= 1'b0;
    end else begin
      if (boundary) begin
        if (swap_pending || bus.swap) begin
          front <= back;
        end
        swap_pending <= 1'b0;
      end else if (bus.swap) begin
        swap_pending <= 1'b1;
      end
      if (wr_ok) begin
        back[bus.wr_row][bus.wr_col] <= bus.wr_data;
      end
    end
  end

endmodule
